// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that sequences four requesters onto a 4:1 single-bit mux.
// Define MUX4_ARB_LOCK_EN to add a LOCK input that lets the owner keep the grant past MAX_HOLD.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       REQ,
  input  logic             A0,
  input  logic             A1,
  input  logic             A2,
  input  logic             A3,
`ifdef MUX4_ARB_LOCK_EN
  input  logic             LOCK,
`endif
  output logic [3:0]       GNT,
  output logic             S0,
  output logic             S1,
  output logic             VALID,
  output logic             Y,
  output logic             DBG_STATE,
  output logic [1:0]       DBG_PTR,
  output logic [CNT_W:0]   DBG_CNT
);

  typedef enum logic {IDLE, GRANT} state_t;

  // One extra bit so MAX_HOLD = 2^CNT_W is still representable.
  localparam logic [CNT_W:0] MAX_CNT = MAX_HOLD[CNT_W:0];

  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [CNT_W:0] cnt_q, cnt_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [1:0]     sel_q, sel_d;

  logic           lock_w;
  logic           lock_hold;
  logic           release_w;
  logic [1:0]     base;
  logic [1:0]     idx;
  logic [1:0]     win;
  logic           mux_y;

`ifdef MUX4_ARB_LOCK_EN
  assign lock_w = LOCK;
`else
  assign lock_w = 1'b0;
`endif

  // On release the search starts just past the owner, so the owner only wins back when alone.
  always_comb begin
    lock_hold = lock_w & REQ[sel_q];
    release_w = (state_q == GRANT) &&
                (!REQ[sel_q] || ((cnt_q >= MAX_CNT) && !lock_hold));
    base = release_w ? (sel_q + 2'd1) : ptr_q;
    win  = base;
    idx  = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (REQ[idx]) win = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          cnt_d   = 1;
        end
      end
      GRANT: begin
        if (!release_w) begin
          if (cnt_q < MAX_CNT) cnt_d = cnt_q + 1'b1;
        end else begin
          ptr_d = sel_q + 2'd1;
          if (|REQ) begin
            gnt_d = 4'b0001 << win;
            sel_d = win;
            cnt_d = 1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            sel_d   = 2'b00;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= 2'b00;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  mux4to1 u_mux (
    .A0 (A0),
    .A1 (A1),
    .A2 (A2),
    .A3 (A3),
    .S0 (sel_q[1]),
    .S1 (sel_q[0]),
    .Y  (mux_y)
  );

  assign GNT       = gnt_q;
  assign S0        = sel_q[1];
  assign S1        = sel_q[0];
  assign VALID     = (state_q == GRANT);
  assign Y         = VALID & mux_y;
  assign DBG_STATE = (state_q == GRANT);
  assign DBG_PTR   = ptr_q;
  assign DBG_CNT   = cnt_q;

endmodule

// Plain 4:1 single-bit mux; {S0,S1} is the index with S0 as MSB.
module mux4to1 (
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic S0,
  input  logic S1,
  output logic Y
);
  always_comb begin
    case ({S0, S1})
      2'b00:   Y = A0;
      2'b01:   Y = A1;
      2'b10:   Y = A2;
      default: Y = A3;
    endcase
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (MAX_HOLD=4 main instance, MAX_HOLD=1 boundary instance).
module tb_mux4_rr_arbiter;

  logic       CLK;
  logic       RST_N;
  logic [3:0] REQ;
  logic       A0, A1, A2, A3;
`ifdef MUX4_ARB_LOCK_EN
  logic       LOCK;
`endif

  logic [3:0] gnt, gnt1;
  logic       s0, s1, valid, y;
  logic       s0_1, s1_1, valid1, y1;
  logic       dbg_state, dbg_state1;
  logic [1:0] dbg_ptr, dbg_ptr1;
  logic [3:0] dbg_cnt, dbg_cnt1;

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] exp_q[$];

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3),
`ifdef MUX4_ARB_LOCK_EN
    .LOCK(LOCK),
`endif
    .GNT(gnt), .S0(s0), .S1(s1), .VALID(valid), .Y(y),
    .DBG_STATE(dbg_state), .DBG_PTR(dbg_ptr), .DBG_CNT(dbg_cnt)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(3)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3),
`ifdef MUX4_ARB_LOCK_EN
    .LOCK(LOCK),
`endif
    .GNT(gnt1), .S0(s0_1), .S1(s1_1), .VALID(valid1), .Y(y1),
    .DBG_STATE(dbg_state1), .DBG_PTR(dbg_ptr1), .DBG_CNT(dbg_cnt1)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ   = 4'b0000;
    #1;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    REQ = 4'b0000;
    {A0, A1, A2, A3} = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
    LOCK = 1'b0;
`endif
    do_reset();
    check("reset_gnt", gnt, 4'b0000);
    check("reset_valid", valid, 1'b0);
    check("reset_sel", {s0, s1}, 2'b00);
    check("reset_y", y, 1'b0);
    check("reset_ptr", dbg_ptr, 2'd0);
    check("reset_cnt", dbg_cnt, 4'd0);

    // Single request from requester 1
    REQ = 4'b0010;
    A1  = 1'b1;
    step();
    check("single_gnt", gnt, 4'b0010);
    check("single_sel", {s0, s1}, 2'b01);
    check("single_valid", valid, 1'b1);
    check("single_y1", y, 1'b1);
    A1 = 1'b0;
    #1;
    check("single_y0", y, 1'b0);
    REQ = 4'b0000;
    step();
    check("single_idle_gnt", gnt, 4'b0000);
    check("single_idle_valid", valid, 1'b0);
    check("single_idle_ptr", dbg_ptr, 2'd2);

    // Fairness: all four requesting, 4-cycle tenures; MAX_HOLD=1 rotates every cycle
    do_reset();
    {A0, A1, A2, A3} = 4'b1010;
    for (int t = 0; t < 5; t++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back(4'b0001 << (t % 4));
    REQ = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] e;
      step();
      e = exp_q.pop_front();
      check("fair_gnt", gnt, e);
      check("fair_valid", valid, 1'b1);
      check("fair_y", y, (e == 4'b0001 || e == 4'b0100) ? 1'b1 : 1'b0);
      check("fair_cnt", dbg_cnt, 4'((i % 4) + 1));
      check("hold1_gnt", gnt1, 4'b0001 << (i % 4));
    end
    check("fair_queue_empty", exp_q.size(), 0);

    // Early release: owner 2 drops REQ during its third grant cycle while 0 waits
    do_reset();
    REQ = 4'b0100;
    step();
    check("early_gnt_c1", gnt, 4'b0100);
    REQ = 4'b0101;
    step();
    check("early_gnt_c2", gnt, 4'b0100);
    step();
    check("early_gnt_c3", gnt, 4'b0100);
    REQ = 4'b0001;
    step();
    check("early_gnt_next", gnt, 4'b0001);
    check("early_sel", {s0, s1}, 2'b00);
    check("early_valid", valid, 1'b1);
    check("early_ptr", dbg_ptr, 2'd3);
    check("early_cnt", dbg_cnt, 4'd1);

    // Expiry re-grant: lone requester 3 keeps the grant with restarted tenures
    do_reset();
    {A0, A1, A2, A3} = 4'b0001;
    REQ = 4'b1000;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("expiry_gnt", gnt, 4'b1000);
      check("expiry_valid", valid, 1'b1);
      check("expiry_cnt", dbg_cnt, 4'(((i - 1) % 4) + 1));
      check("expiry_y", y, 1'b1);
    end
    check("expiry_sel", {s0, s1}, 2'b11);

    // Asynchronous reset in the middle of a tenure
    do_reset();
    {A0, A1, A2, A3} = 4'b0010;
    REQ = 4'b0100;
    step();
    check("midrst_pre_gnt", gnt, 4'b0100);
    check("midrst_pre_y", y, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_sel", {s0, s1}, 2'b00);
    check("midrst_valid", valid, 1'b0);
    check("midrst_y", y, 1'b0);
    REQ = 4'b0000;
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_outs", {gnt, s0, s1, valid, y}, 8'h00);
    end

`ifdef MUX4_ARB_LOCK_EN
    // Lock keeps owner 0 past MAX_HOLD; dropping it hands over on the next edge
    do_reset();
    REQ = 4'b0011;
    step();
    check("lock_first_gnt", gnt, 4'b0001);
    LOCK = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("lock_hold_gnt", gnt, 4'b0001);
    end
    check("lock_cnt_sat", dbg_cnt, 4'd4);
    LOCK = 1'b0;
    step();
    check("lock_release_gnt", gnt, 4'b0010);
    check("lock_release_sel", {s0, s1}, 2'b01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
